id_ex_stage: RTL

//  ID/EX pipeline register of the 5-stage MIPS pipeline, directly downstream of the Control decoder.

---
 rtl/id_ex_stage.sv | 139 +++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use / branch-operand hazard detection.
// Optional build macro: ID_EX_PERF_CNT_EN adds bubble_cnt and stall_cycles
// performance counters; without it those ports and counters do not exist.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          hold,
  input  logic          flush,
  input  logic [1:0]    id_ALUOp,
  input  logic          id_RegDst,
  input  logic          id_MemRead,
  input  logic          id_MemtoReg,
  input  logic          id_MemWrite,
  input  logic          id_ALUSrc,
  input  logic          id_RegWrite,
  input  logic          id_Ins_Beq,
  input  logic          id_Ins_Bne,
  input  logic [DW-1:0] id_pc_plus4,
  input  logic [DW-1:0] id_rdata1,
  input  logic [DW-1:0] id_rdata2,
  input  logic [DW-1:0] id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          mem_MemRead,
  input  logic [RW-1:0] mem_wreg,
  output logic [1:0]    ex_ALUOp,
  output logic          ex_RegDst,
  output logic          ex_MemRead,
  output logic          ex_MemtoReg,
  output logic          ex_MemWrite,
  output logic          ex_ALUSrc,
  output logic          ex_RegWrite,
  output logic [DW-1:0] ex_pc_plus4,
  output logic [DW-1:0] ex_rdata1,
  output logic [DW-1:0] ex_rdata2,
  output logic [DW-1:0] ex_imm,
  output logic [RW-1:0] ex_rs,
  output logic [RW-1:0] ex_rt,
  output logic [RW-1:0] ex_rd,
  output logic [RW-1:0] ex_wreg,
`ifdef ID_EX_PERF_CNT_EN
  output logic [31:0]   bubble_cnt,
  output logic [31:0]   stall_cycles,
`endif
  output logic          pc_write,
  output logic          if_id_write
);

  // Register 0 is hardwired to zero, so a producer targeting it never creates a dependency.
  function automatic logic reg_match(input logic [RW-1:0] producer, input logic [RW-1:0] consumer);
    return (consumer != '0) && (producer == consumer);
  endfunction

  logic is_branch;
  logic load_use;
  logic br_ex;
  logic br_mem;
  logic stall;
  logic bubble;

  // Hazard detection and front-end write enables.
  always_comb begin
    is_branch   = id_Ins_Beq | id_Ins_Bne;
    load_use    = ex_MemRead & (reg_match(ex_rt, id_rs) | reg_match(ex_rt, id_rt));
    br_ex       = is_branch & ex_RegWrite & (reg_match(ex_wreg, id_rs) | reg_match(ex_wreg, id_rt));
    br_mem      = is_branch & mem_MemRead & (reg_match(mem_wreg, id_rs) | reg_match(mem_wreg, id_rt));
    stall       = load_use | br_ex | br_mem;
    bubble      = stall | flush;
    pc_write    = reset | ~(stall | hold);
    if_id_write = reset | ~(stall | hold);
  end

  // Pipeline register: reset > hold > bubble > load.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_ALUOp    <= '0;
      ex_RegDst   <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemtoReg <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_ALUSrc   <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_pc_plus4 <= '0;
      ex_rdata1   <= '0;
      ex_rdata2   <= '0;
      ex_imm      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
      ex_wreg     <= '0;
    end else if (!hold) begin
      // Data fields load even for a bubble; they are don't-care once control is zero.
      ex_pc_plus4 <= id_pc_plus4;
      ex_rdata1   <= id_rdata1;
      ex_rdata2   <= id_rdata2;
      ex_imm      <= id_imm;
      ex_rs       <= id_rs;
      ex_rt       <= id_rt;
      ex_rd       <= id_rd;
      if (bubble) begin
        ex_ALUOp    <= '0;
        ex_RegDst   <= 1'b0;
        ex_MemRead  <= 1'b0;
        ex_MemtoReg <= 1'b0;
        ex_MemWrite <= 1'b0;
        ex_ALUSrc   <= 1'b0;
        ex_RegWrite <= 1'b0;
        ex_wreg     <= '0;
      end else begin
        ex_ALUOp    <= id_ALUOp;
        ex_RegDst   <= id_RegDst;
        ex_MemRead  <= id_MemRead;
        ex_MemtoReg <= id_MemtoReg;
        ex_MemWrite <= id_MemWrite;
        ex_ALUSrc   <= id_ALUSrc;
        ex_RegWrite <= id_RegWrite;
        ex_wreg     <= id_RegDst ? id_rd : id_rt;
      end
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  // Bubble and stall-cycle counters; a held cycle counts as neither.
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt   <= '0;
      stall_cycles <= '0;
    end else if (!hold) begin
      if (bubble) bubble_cnt <= bubble_cnt + 32'd1;
      if (stall)  stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
